counter_x: RTL and testbench
============================

Name: counter_x

Overview:
- Three-channel 32-bit programmable down-counter peripheral at 0xFFFF_FF04.
- Sits directly downstream of the MIO bus decoder:
  - consumes its counter_we strobe and Peripheral_in write data;
  - returns counter_out for CPU reads;
  - returns the counter0_out/counter1_out/counter2_out status bits, which the decoder packs into the 0xFFFF_FF00 GPIO read word.
- Channel/register select comes from the GPIO control latch (the counter_set field).

Parameters:
- PRESCALE, 1, clk cycles per count tick; legal range 1..65535; shared by all channels.
- CNT_W, 32, counter and reload register width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- counter_we  input  1  write strobe from the bus decoder, one cycle per store.
- counter_ch  input  2  select: 00/01/10 = channel 0/1/2 reload; 11 = control word. Applies to both write and readback.
- counter_val  input  CNT_W  write data (Peripheral_in).
- counter_out  output  CNT_W  readback. Channel select gives that channel's current count; 11 gives the control word zero-extended.
- counter0_out  output  1  channel 0 status output.
- counter1_out  output  1  channel 1 status output.
- counter2_out  output  1  channel 2 status output.

Behaviour:
- Reset (rst==0 at a rising edge) clears:
  - all counts and reloads to 0;
  - control word to 0 (all channels disabled, mode 00);
  - prescaler to 0;
  - counter0/1/2_out to 0.
- Reset mid-count aborts everything, with no terminal event.
- Control word layout:
  - [1:0] ch0 mode, [3:2] ch1 mode, [5:4] ch2 mode;
  - [8:6] enable for ch0..ch2;
  - [31:9] ignored on write, read as 0.
- Modes:
  - 00 one-shot;
  - 01 rate (periodic pulse);
  - 10 square wave;
  - 11 hold (count frozen, out frozen).
- Prescaler:
  - free-running 0..PRESCALE-1;
  - tick asserted for one clk in the cycle the prescaler equals PRESCALE-1, then it wraps to 0;
  - PRESCALE=1 gives a tick every cycle.
- Writing a channel (counter_we && counter_ch==n):
  - reload_n and count_n both take counter_val at that edge;
  - out_n is cleared to 0;
  - visible on counter_out the following cycle (registered).
- Writing the control word (ch==11):
  - takes effect at that edge;
  - does not alter counts or outs.
- Per tick, for each channel that is enabled, in a mode other than 11, with count != 0:
  - count > 1: decrement.
  - count == 1 (terminal), one-shot: count becomes 0; out becomes 1 and is held; the channel stops until reloaded.
  - count == 1 (terminal), rate: count becomes reload; out is 1 for exactly one clk (cleared next cycle).
  - count == 1 (terminal), square: count becomes reload; out toggles. The output period is 2*reload ticks.
- Boundary conditions:
  - Reload 0: the channel is idle, count stays 0, out stays low.
  - Reload 1 in rate mode: out pulses on every tick.
  - Write and tick on the same channel in the same cycle: the write wins and the tick is lost for that channel only. Other channels tick normally.
  - Disable while counting: count and out freeze. Re-enabling resumes from the frozen count.
  - Channels are fully independent apart from the shared tick.
- Status output timing: counter0/1/2_out are registered; they change one edge after the terminal tick cycle.

Optional Feature:
- Macro: COUNTER_IRQ_EN.
- Defined:
  - adds output counter_irq (1 bit), a sticky OR of all channel terminal events;
  - set the cycle after a terminal event;
  - cleared by any control-word write. If a terminal event and a clear coincide, the set wins.
  - reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package counter_pkg:
  - mode encodings MODE_ONESHOT=2'b00, MODE_RATE=2'b01, MODE_SQUARE=2'b10, MODE_HOLD=2'b11;
  - select encoding SEL_CTRL=2'b11;
  - control-word bit positions.
- Sub-module counter_chan: one down-counter with reload, mode and out logic, instantiated three times.
- The top level owns the prescaler, control register, write decode and readback mux.

Test Plan:
- Reset: hold rst=0 for 2 cycles → counter_out=0 for all selects; counter0/1/2_out=0.
- One-shot, PRESCALE=1: write ch0=5; ctrl=0x040 (en0, mode 00) → counter0_out rises 5 ticks after enable, count reads 0, out stays 1 for 100+ cycles.
- Rate: ch1 reload 3; ctrl en1, mode 01 → counter1_out is a 1-cycle pulse every 3 clk; readback cycles 3,2,1,3.
- Square, PRESCALE=4: ch2 reload 2, mode 10 → counter2_out toggles every 8 clk (period 16).
- Collision: ch0 counting at 7; write 100 on a tick cycle → next-cycle readback is 100, not 99. A ch1 counting concurrently decrements normally.
- Disable and reload-0: clear en0 at count 4 → count holds 4 for 20 cycles; re-enable → resumes at 3. Write ch0=0 → stays 0, out low.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants for the counter_x peripheral: channel modes, the select
// code for the control word, and the control-word field positions.
package counter_pkg;

  localparam int NUM_CH = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RATE    = 2'b01;
  localparam logic [1:0] MODE_SQUARE  = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;

  localparam logic [1:0] SEL_CTRL = 2'b11;

  // [1:0]/[3:2]/[5:4] per-channel mode, [8:6] per-channel enable
  localparam int CTRL_MODE_W = 2;
  localparam int CTRL_EN_LSB = 6;
  localparam int CTRL_W      = 9;

endpackage

// File: rtl/counter_x_if.sv
// Bus-side signals of counter_x. The MIO decoder is the master; the
// counter block is the slave. counter_irq exists only when COUNTER_IRQ_EN
// is defined.
interface counter_x_if #(parameter int CNT_W = 32);

  logic             counter_we;
  logic [1:0]       counter_ch;
  logic [CNT_W-1:0] counter_val;
  logic [CNT_W-1:0] counter_out;
  logic             counter0_out;
  logic             counter1_out;
  logic             counter2_out;
`ifdef COUNTER_IRQ_EN
  logic             counter_irq;
`endif

  modport master (
    output counter_we, counter_ch, counter_val,
    input  counter_out, counter0_out, counter1_out, counter2_out
`ifdef COUNTER_IRQ_EN
    , input counter_irq
`endif
  );

  modport slave (
    input  counter_we, counter_ch, counter_val,
    output counter_out, counter0_out, counter1_out, counter2_out
`ifdef COUNTER_IRQ_EN
    , output counter_irq
`endif
  );

endinterface

// File: rtl/counter_chan.sv
// One down-counter channel: reload register, count, and mode-dependent
// status output. A write on the same edge as a tick wins over the tick.
// term_o (terminal event) exists only when COUNTER_IRQ_EN is defined.
module counter_chan
  import counter_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_val_i,
  output logic [CNT_W-1:0] count_o,
`ifdef COUNTER_IRQ_EN
  output logic             term_o,
`endif
  output logic             out_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic             out_q, out_d;
  // Marks that out_q holds a rate-mode pulse which must drop after one clk.
  logic             pulse_q, pulse_d;
  logic             active;

  assign active = tick_i && en_i && (mode_i != MODE_HOLD) && (count_q != '0);

`ifdef COUNTER_IRQ_EN
  assign term_o = active && !wr_i && (count_q == CNT_W'(1));
`endif

  // Next-state: write, else decrement / terminal action on an active tick.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    out_d    = out_q;
    pulse_d  = 1'b0;
    if (pulse_q) out_d = 1'b0;
    if (wr_i) begin
      reload_d = wr_val_i;
      count_d  = wr_val_i;
      out_d    = 1'b0;
    end else if (active) begin
      if (count_q != CNT_W'(1)) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        case (mode_i)
          MODE_ONESHOT: begin
            count_d = '0;
            out_d   = 1'b1;
          end
          MODE_RATE: begin
            count_d = reload_q;
            out_d   = 1'b1;
            pulse_d = 1'b1;
          end
          MODE_SQUARE: begin
            count_d = reload_q;
            out_d   = ~out_d;
          end
          default: ;
        endcase
      end
    end
  end

  // Channel state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q  <= '0;
      reload_q <= '0;
      out_q    <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      out_q    <= out_d;
      pulse_q  <= pulse_d;
    end
  end

  assign count_o = count_q;
  assign out_o   = out_q;

endmodule

// File: rtl/counter_x.sv
// counter_x: three-channel programmable down-counter at 0xFFFF_FF04.
// Owns the shared prescaler, the control word, write decode and readback.
// Optional feature macro: COUNTER_IRQ_EN adds the sticky counter_irq output.
module counter_x
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1,
  parameter int CNT_W    = 32
) (
  input  logic       clk,
  input  logic       rst,
  counter_x_if.slave bus
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [15:0]       pre_q, pre_d;
  logic              tick;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              ctrl_wr;
  logic [CNT_W-1:0]  count [NUM_CH];
  logic [NUM_CH-1:0] chan_out;

  assign tick    = (pre_q == PRE_LAST);
  assign pre_d   = tick ? 16'd0 : pre_q + 16'd1;
  assign ctrl_wr = bus.counter_we && (bus.counter_ch == SEL_CTRL);
  assign ctrl_d  = ctrl_wr ? bus.counter_val[CTRL_W-1:0] : ctrl_q;

  // Prescaler and control word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_q  <= '0;
      ctrl_q <= '0;
    end else begin
      pre_q  <= pre_d;
      ctrl_q <= ctrl_d;
    end
  end

`ifdef COUNTER_IRQ_EN
  logic [NUM_CH-1:0] term;
  logic              irq_q, irq_d;

  // A terminal event coinciding with a control-word write keeps irq set.
  assign irq_d = (irq_q && !ctrl_wr) || (|term);

  // Sticky terminal-event flag.
  always_ff @(posedge clk) begin
    if (!rst) irq_q <= 1'b0;
    else      irq_q <= irq_d;
  end

  assign bus.counter_irq = irq_q;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    counter_chan #(.CNT_W(CNT_W)) u_chan (
      .clk      (clk),
      .rst      (rst),
      .tick_i   (tick),
      .en_i     (ctrl_q[CTRL_EN_LSB + i]),
      .mode_i   (ctrl_q[CTRL_MODE_W*i +: CTRL_MODE_W]),
      .wr_i     (bus.counter_we && (bus.counter_ch == 2'(i))),
      .wr_val_i (bus.counter_val),
      .count_o  (count[i]),
`ifdef COUNTER_IRQ_EN
      .term_o   (term[i]),
`endif
      .out_o    (chan_out[i])
    );
  end

  // Readback mux: selected channel count, or the control word zero-extended.
  always_comb begin
    bus.counter_out = '0;
    case (bus.counter_ch)
      2'b00:   bus.counter_out = count[0];
      2'b01:   bus.counter_out = count[1];
      2'b10:   bus.counter_out = count[2];
      default: bus.counter_out = CNT_W'(ctrl_q);
    endcase
  end

  assign bus.counter0_out = chan_out[0];
  assign bus.counter1_out = chan_out[1];
  assign bus.counter2_out = chan_out[2];

endmodule

// File: tb/tb_counter_x.sv
// Bench for counter_x: two instances (PRESCALE=1 and PRESCALE=4) driven by
// the same stimulus and checked every cycle against a rule-level model.
module tb_counter_x;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  counter_x_if #(.CNT_W(32)) bus_a ();
  counter_x_if #(.CNT_W(32)) bus_b ();

  counter_x #(.PRESCALE(1), .CNT_W(32)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  counter_x #(.PRESCALE(4), .CNT_W(32)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_cmp = 0;
  int n_err = 0;

  // Model state, [instance][channel]
  logic [31:0] m_cnt    [2][3];
  logic [31:0] m_rld    [2][3];
  bit          m_steady [2][3];
  int          m_pulse  [2][3];  // edge number at which a rate pulse was emitted
  logic [8:0]  m_ctrl   [2];
  int          m_e      [2];     // edges since reset released
  bit          m_irq    [2];
  logic [1:0]  cur_ch;

  function automatic int ps(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_out(input int d, input int c);
    return m_steady[d][c] || (m_pulse[d][c] == m_e[d]);
  endfunction

  task automatic model_edge(input bit r, input bit we, input logic [1:0] ch, input logic [31:0] val);
    for (int d = 0; d < 2; d++) begin
      if (!r) begin
        for (int c = 0; c < 3; c++) begin
          m_cnt[d][c] = '0; m_rld[d][c] = '0; m_steady[d][c] = 0; m_pulse[d][c] = -1;
        end
        m_ctrl[d] = '0; m_e[d] = 0; m_irq[d] = 0;
      end else begin
        bit tick;
        bit any;
        any = 0;
        m_e[d]++;
        tick = ((m_e[d] - 1) % ps(d)) == ps(d) - 1;
        for (int c = 0; c < 3; c++) begin
          logic [1:0] mode;
          bit en;
          mode = m_ctrl[d][2*c +: 2];
          en   = m_ctrl[d][6+c];
          if (we && ch == 2'(c)) begin
            m_cnt[d][c] = val; m_rld[d][c] = val; m_steady[d][c] = 0; m_pulse[d][c] = -1;
          end else if (tick && en && mode != 2'b11 && m_cnt[d][c] != 0) begin
            if (m_cnt[d][c] > 1) m_cnt[d][c] = m_cnt[d][c] - 1;
            else begin
              any = 1;
              if (mode == 2'b00) begin
                m_cnt[d][c] = 0; m_steady[d][c] = 1;
              end else if (mode == 2'b01) begin
                m_cnt[d][c] = m_rld[d][c]; m_steady[d][c] = 0; m_pulse[d][c] = m_e[d];
              end else begin
                m_cnt[d][c] = m_rld[d][c]; m_steady[d][c] = !m_steady[d][c];
              end
            end
          end
        end
        if (we && ch == 2'b11) begin
          m_ctrl[d] = val[8:0];
          m_irq[d]  = any;
        end else begin
          m_irq[d] = m_irq[d] || any;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_a, exp_b;
    exp_a = (cur_ch == 2'b11) ? {23'b0, m_ctrl[0]} : m_cnt[0][cur_ch];
    exp_b = (cur_ch == 2'b11) ? {23'b0, m_ctrl[1]} : m_cnt[1][cur_ch];
    chk("a_read", bus_a.counter_out, exp_a);
    chk("a_out0", 32'(bus_a.counter0_out), 32'(m_out(0, 0)));
    chk("a_out1", 32'(bus_a.counter1_out), 32'(m_out(0, 1)));
    chk("a_out2", 32'(bus_a.counter2_out), 32'(m_out(0, 2)));
    chk("b_read", bus_b.counter_out, exp_b);
    chk("b_out0", 32'(bus_b.counter0_out), 32'(m_out(1, 0)));
    chk("b_out1", 32'(bus_b.counter1_out), 32'(m_out(1, 1)));
    chk("b_out2", 32'(bus_b.counter2_out), 32'(m_out(1, 2)));
`ifdef COUNTER_IRQ_EN
    chk("a_irq", 32'(bus_a.counter_irq), 32'(m_irq[0]));
    chk("b_irq", 32'(bus_b.counter_irq), 32'(m_irq[1]));
`endif
  endtask

  // One clock: drive inputs now (just after negedge), step model at the
  // edge, compare at the following negedge.
  task automatic cyc(input bit r, input bit we, input logic [1:0] ch, input logic [31:0] val);
    rst = r;
    cur_ch = ch;
    bus_a.counter_we = we; bus_a.counter_ch = ch; bus_a.counter_val = val;
    bus_b.counter_we = we; bus_b.counter_ch = ch; bus_b.counter_val = val;
    @(posedge clk);
    model_edge(r, we, ch, val);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n, input logic [1:0] ch);
    for (int k = 0; k < n; k++) cyc(1, 0, ch, 32'h0);
  endtask

  initial begin
    bit reached;
    rst = 1'b0;
    cur_ch = 2'b00;
    bus_a.counter_we = 0; bus_a.counter_ch = 0; bus_a.counter_val = 0;
    bus_b.counter_we = 0; bus_b.counter_ch = 0; bus_b.counter_val = 0;

    // Reset: two cycles low, then every select reads 0.
    cyc(0, 0, 2'b00, 0);
    cyc(0, 0, 2'b00, 0);
    for (int s = 0; s < 4; s++) begin
      cyc(1, 0, 2'(s), 0);
      chk("rst_read", bus_a.counter_out, 32'h0);
    end

    // One-shot, reload 5.
    cyc(1, 1, 2'b00, 32'd5);
    cyc(1, 1, 2'b11, 32'h040);
    idle(4, 2'b00);
    chk("os_not_yet", 32'(bus_a.counter0_out), 32'h0);
    idle(1, 2'b00);
    chk("os_rise", 32'(bus_a.counter0_out), 32'h1);
    idle(110, 2'b00);
    chk("os_hold", 32'(bus_a.counter0_out), 32'h1);
    chk("os_zero", bus_a.counter_out, 32'h0);

    // Rate on ch1, reload 3.
    cyc(1, 1, 2'b01, 32'd3);
    cyc(1, 1, 2'b11, 32'h084);
    idle(14, 2'b01);

    // Square on ch2, reload 2.
    cyc(1, 1, 2'b10, 32'd2);
    cyc(1, 1, 2'b11, 32'h1A4);
    idle(48, 2'b10);

    // Collision on dut_b: ch0 counting from 7, ch1 counting concurrently.
    cyc(1, 1, 2'b11, 32'h000);
    cyc(1, 1, 2'b00, 32'd7);
    cyc(1, 1, 2'b01, 32'd50);
    cyc(1, 1, 2'b11, 32'h0C0);
    reached = 0;
    for (int k = 0; k < 16 && !reached; k++) begin
      if ((m_e[1] % 4) == 3 && m_cnt[1][0] < 7 && m_cnt[1][0] > 1) reached = 1;
      else cyc(1, 0, 2'b00, 0);
    end
    chk("coll_reach", 32'(reached), 32'h1);
    cyc(1, 1, 2'b00, 32'd100);
    chk("coll_write", bus_b.counter_out, 32'd100);
    idle(8, 2'b01);

    // Disable at count 4, hold, re-enable, then reload 0 (on dut_a).
    cyc(1, 1, 2'b00, 32'd10);
    reached = 0;
    for (int k = 0; k < 40 && !reached; k++) begin
      if (m_cnt[0][0] == 5) reached = 1;
      else cyc(1, 0, 2'b00, 0);
    end
    chk("dis_reach", 32'(reached), 32'h1);
    cyc(1, 1, 2'b11, 32'h000);
    idle(20, 2'b00);
    chk("dis_hold", bus_a.counter_out, 32'd4);
    cyc(1, 1, 2'b11, 32'h040);
    idle(1, 2'b00);
    chk("dis_resume", bus_a.counter_out, 32'd3);
    cyc(1, 1, 2'b00, 32'd0);
    idle(10, 2'b00);
    chk("zero_cnt", bus_a.counter_out, 32'd0);
    chk("zero_out", 32'(bus_a.counter0_out), 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, we;
      logic [1:0] ch;
      logic [31:0] val;
      r  = ($urandom % 700) != 0;
      we = ($urandom % 8) == 0;
      ch = 2'($urandom % 4);
      if (ch == 2'b11)            val = $urandom % 512;
      else if ($urandom % 6 == 0) val = $urandom;
      else                        val = $urandom % 9;
      cyc(r, we, ch, val);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
